// File: rtl/hypercpu_bus_dma.sv
// Bus-initiator DMA: copies len words from src to dst over the shared word bus, 2 cycles/word.
// Optional HYPERCPU_DMA_FILL_EN adds a fill mode that writes one constant value, 1 cycle/word.
module hypercpu_bus_dma #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef HYPERCPU_DMA_FILL_EN
    input  logic              fill_mode,
    input  logic [ADDR_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic              bus_request,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_enabled,
    input  logic [ADDR_W-1:0] mem_read,
    output logic              mem_write_enabled,
    output logic [ADDR_W-1:0] mem_write
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    logic [2:0]        state_reg;
    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  idx_reg;
    logic [ADDR_W-1:0] data_reg;
    logic              fill_active;
    logic [ADDR_W-1:0] wdata;
    logic              last_word;
    logic              drive_rd;
    logic              drive_wr;

`ifdef HYPERCPU_DMA_FILL_EN
    logic              fill_reg;
    logic [ADDR_W-1:0] fill_value_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_reg       <= 1'b0;
            fill_value_reg <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            fill_reg       <= fill_mode;
            fill_value_reg <= fill_value;
        end
    end

    assign fill_active = fill_reg;
    assign wdata       = fill_reg ? fill_value_reg : data_reg;
`else
    assign fill_active = 1'b0;
    assign wdata       = data_reg;
`endif

    // idx never reaches len, so idx+1 cannot overflow LEN_W
    assign last_word = ((idx_reg + LEN_W'(1)) == len_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            len_reg   <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        src_reg   <= src_addr;
                        dst_reg   <= dst_addr;
                        len_reg   <= len;
                        idx_reg   <= '0;
                        state_reg <= (len == '0) ? ST_FIN : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_grant) state_reg <= fill_active ? ST_WR : ST_RD;
                end
                ST_RD: begin
                    if (bus_grant) begin
                        data_reg  <= mem_read;
                        state_reg <= ST_WR;
                    end
                end
                ST_WR: begin
                    // a lost grant freezes the word in place until the bus comes back
                    if (bus_grant) begin
                        idx_reg <= idx_reg + LEN_W'(1);
                        if (last_word)        state_reg <= ST_FIN;
                        else if (fill_active) state_reg <= ST_WR;
                        else                  state_reg <= ST_RD;
                    end
                end
                ST_FIN:  state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state_reg == ST_REQ) || (state_reg == ST_RD) || (state_reg == ST_WR);
    assign bus_request = busy;
    assign done        = (state_reg == ST_FIN);

    assign drive_rd = bus_grant && (state_reg == ST_RD);
    assign drive_wr = bus_grant && (state_reg == ST_WR);

    assign mem_addr          = drive_rd ? (src_reg + ADDR_W'(idx_reg)) :
                               drive_wr ? (dst_reg + ADDR_W'(idx_reg)) : 'z;
    assign mem_read_enabled  = drive_rd ? 1'b1 : 1'bz;
    assign mem_write_enabled = drive_wr ? 1'b1 : 1'bz;
    assign mem_write         = drive_wr ? wdata : 'z;

endmodule

// File: tb/tb_hypercpu_bus_dma.sv
// Bench for hypercpu_bus_dma: expected write/read lists and done latency come from a
// transfer-level model (word i of dst gets source word i) rather than from the FSM.
module tb_hypercpu_bus_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        bus_request;
    logic        bus_grant;
    wire  [31:0] mem_addr;
    wire         mem_read_enabled;
    wire  [31:0] mem_read;
    wire         mem_write_enabled;
    wire  [31:0] mem_write;
`ifdef HYPERCPU_DMA_FILL_EN
    logic        fill_mode;
    logic [31:0] fill_value;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rd_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          viol;
    bit          req_seen;

    always #5 clk = ~clk;

    hypercpu_bus_dma #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .src_addr         (src_addr),
        .dst_addr         (dst_addr),
        .len              (len),
`ifdef HYPERCPU_DMA_FILL_EN
        .fill_mode        (fill_mode),
        .fill_value       (fill_value),
`endif
        .busy             (busy),
        .done             (done),
        .bus_request      (bus_request),
        .bus_grant        (bus_grant),
        .mem_addr         (mem_addr),
        .mem_read_enabled (mem_read_enabled),
        .mem_read         (mem_read),
        .mem_write_enabled(mem_write_enabled),
        .mem_write        (mem_write)
    );

    // source responder: boot ROM words at 0 and 14, hashed content elsewhere
    function automatic logic [31:0] src_word(input logic [31:0] a);
        if (a == 32'h0)  return 32'hfc21_0000;
        if (a == 32'hE)  return 32'hfc2f_000a;
        return (a * 32'h9E37_79B1) + 32'h0123_4567;
    endfunction

    assign mem_read = src_word(mem_addr);

    always @(negedge clk) begin
        if (mem_read_enabled === 1'b1) rd_q.push_back(mem_addr);
        if (mem_write_enabled === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_write);
        end
        if (bus_grant !== 1'b1 && (mem_read_enabled === 1'b1 || mem_write_enabled === 1'b1))
            viol++;
        if (bus_request === 1'b1) req_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        src_addr = $urandom;
        dst_addr = $urandom;
        len      = 16'($urandom);
`ifdef HYPERCPU_DMA_FILL_EN
        fill_mode  = 1'($urandom);
        fill_value = $urandom;
`endif
    endtask

    // g0/gn: grant held low for cycles g0..g0+gn-1 (cycle 0 = start cycle)
    task automatic run_xfer(input string name, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input int g0, input int gn,
                            input bit poke, input bit fill, input logic [31:0] fv);
        int lat;
        int exp_lat;
        int limit;
        int cnt;
        logic [31:0] exp_d;
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        viol = 0;
        req_seen = 1'b0;
        exp_lat = (n == 0) ? 1 : (1 + (fill ? int'(n) : 2 * int'(n)) + 1 + gn);
        limit = exp_lat + 20;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = n;
`ifdef HYPERCPU_DMA_FILL_EN
        fill_mode = fill; fill_value = fv;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        lat = -1;
        for (int c = 1; c <= limit; c++) begin
            bus_grant = (c >= g0 && c < g0 + gn) ? 1'b0 : 1'b1;
            start = poke && (c == 3);
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            check({name, "_busy"}, {31'b0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus_grant = 1'b1;
        check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        check({name, "_done_cycle"}, lat, exp_lat);
        check({name, "_nwrites"}, wa_q.size(), n);
        check({name, "_nreads"}, rd_q.size(), fill ? 0 : n);
        check({name, "_ungranted_drive"}, viol, 0);
        check({name, "_req_seen"}, {31'b0, req_seen}, {31'b0, n != 0});
        cnt = (wa_q.size() < int'(n)) ? wa_q.size() : int'(n);
        for (int i = 0; i < cnt; i++) begin
            exp_d = fill ? fv : src_word(s + 32'(i));
            check($sformatf("%s_waddr%0d", name, i), wa_q[i], d + 32'(i));
            check($sformatf("%s_wdata%0d", name, i), wd_q[i], exp_d);
        end
        cnt = (rd_q.size() < int'(n)) ? rd_q.size() : int'(n);
        for (int i = 0; i < cnt; i++)
            check($sformatf("%s_raddr%0d", name, i), rd_q[i], s + 32'(i));
        @(posedge clk); #1;
        check({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
        check({name, "_idle_done"}, {31'b0, done}, 32'd0);
        $display("xfer %s src=%h dst=%h len=%0d stall=%0d done_cycle=%0d writes=%0d",
                 name, s, d, n, gn, lat, wa_q.size());
    endtask

    initial begin
        logic [15:0] rn;
        int          rk;
        rst_n = 1'b0;
        bus_grant = 1'b1;
        start = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_req", {31'b0, bus_request}, 32'd0);
        check("rst_rden", {31'b0, mem_read_enabled === 1'b1}, 32'd0);
        check("rst_wren", {31'b0, mem_write_enabled === 1'b1}, 32'd0);
        rst_n = 1'b1;

        run_xfer("boot", 32'h0, 32'h0100_0000, 16'd15, 0, 0, 1'b0, 1'b0, 32'h0);
        check("boot_ram0", wd_q.size() > 0 ? wd_q[0] : 32'h0, 32'hfc21_0000);
        check("boot_ram14", wd_q.size() > 14 ? wd_q[14] : 32'h0, 32'hfc2f_000a);

        run_xfer("len0", 32'h40, 32'h80, 16'd0, 0, 0, 1'b0, 1'b0, 32'h0);
        // word 4 RD falls in cycle 2+2*4
        run_xfer("stall_rd4", 32'h0, 32'h0100_0000, 16'd15, 10, 3, 1'b0, 1'b0, 32'h0);
        run_xfer("wrap", 32'hFFFF_FFFE, 32'h0000_0500, 16'd4, 0, 0, 1'b0, 1'b0, 32'h0);
        run_xfer("req_wait_poke", 32'h1000, 32'h2000, 16'd6, 1, 4, 1'b1, 1'b0, 32'h0);

        for (int t = 0; t < 6; t++) begin
            rn = 16'($urandom_range(1, 20));
            rk = $urandom_range(0, int'(rn) - 1);
            run_xfer($sformatf("rand%0d", t), $urandom, $urandom, rn, 2 + 2 * rk,
                     $urandom_range(0, 4), 1'($urandom), 1'b0, 32'h0);
        end

`ifdef HYPERCPU_DMA_FILL_EN
        run_xfer("fill", 32'h0, 32'hA000_0000, 16'd8, 0, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);
`endif

        // abort after two words have been written
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        @(negedge clk);
        src_addr = 32'h100; dst_addr = 32'h200; len = 16'd8;
`ifdef HYPERCPU_DMA_FILL_EN
        fill_mode = 1'b0;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_req", {31'b0, bus_request}, 32'd0);
        check("abort_rden", {31'b0, mem_read_enabled === 1'b1}, 32'd0);
        check("abort_wren", {31'b0, mem_write_enabled === 1'b1}, 32'd0);
        check("abort_nwrites", wa_q.size(), 32'd2);
        check("abort_waddr1", wa_q.size() > 1 ? wa_q[1] : 32'h0, 32'h201);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_done", {31'b0, done}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_stays_idle", {31'b0, busy}, 32'd0);
        check("abort_no_more_writes", wa_q.size(), 32'd2);
        $display("xfer abort src=00000100 dst=00000200 len=8 writes=%0d", wa_q.size());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
